key_debounce: RTL



---
 rtl/key_debounce.sv | 130 +++++++++++++
 1 files changed

// File: rtl/key_debounce.sv
// key_debounce: multi-channel push-button conditioner for the front panel.
// Each key is optionally inverted, synchronised into clk, debounced with its
// own stable-time counter, and turned into a clean level plus one-cycle
// press / release / long-press pulses.
// Optional build macro: KEY_REPEAT_EN adds per-key auto-repeat of key_press
// every REPEAT cycles after key_long while the key stays held.
module key_debounce #(
  parameter int N_KEYS     = 4,
  parameter int DELAY      = 5000,
  parameter int LONG       = 40000000,
  parameter int REPEAT     = 8000000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int DW = $clog2(DELAY + 1);
  localparam int HW = $clog2(LONG + 1);

  logic [N_KEYS-1:0] raw;
  logic [N_KEYS-1:0] sync1_q, sync_q;
  logic [N_KEYS-1:0] level_q, press_q, release_q, long_q;
  logic [N_KEYS-1:0] level_d, press_d, release_d, long_d;
  logic [N_KEYS-1:0] accept;
  logic [DW-1:0]     dcnt_q [N_KEYS];
  logic [DW-1:0]     dcnt_d [N_KEYS];
  logic [HW-1:0]     hcnt_q [N_KEYS];
  logic [HW-1:0]     hcnt_d [N_KEYS];

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT + 1);
  logic [RW-1:0]     rcnt_q [N_KEYS];
  logic [RW-1:0]     rcnt_d [N_KEYS];
`endif

  // Normalise polarity so that 1 always means pressed from here on.
  assign raw = (ACTIVE_LOW != 0) ? ~key_in : key_in;

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

  // Per-key next state: debounce filter, hold timer and optional repeat timer.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i]    = (sync_q[i] != level_q[i]) && (dcnt_q[i] == DW'(DELAY - 1));
      level_d[i]   = level_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;
      long_d[i]    = 1'b0;
      dcnt_d[i]    = '0;
      hcnt_d[i]    = hcnt_q[i];

      // Any sample equal to the current level restarts the stable count.
      if (sync_q[i] == level_q[i]) begin
        dcnt_d[i] = '0;
      end else if (accept[i]) begin
        level_d[i]   = sync_q[i];
        press_d[i]   = sync_q[i];
        release_d[i] = ~sync_q[i];
        dcnt_d[i]    = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DW'(1);
      end

      // Clearing on any accepted change makes a release that lands on the
      // LONG edge win over key_long.
      if (!level_q[i] || accept[i]) begin
        hcnt_d[i] = '0;
      end else if (hcnt_q[i] != HW'(LONG)) begin
        hcnt_d[i] = hcnt_q[i] + HW'(1);
        long_d[i] = (hcnt_q[i] == HW'(LONG - 1));
      end

`ifdef KEY_REPEAT_EN
      // Repeat timer only runs once the hold timer has saturated.
      rcnt_d[i] = '0;
      if (level_q[i] && !accept[i] && (hcnt_q[i] == HW'(LONG))) begin
        if (rcnt_q[i] == RW'(REPEAT - 1)) begin
          press_d[i] = 1'b1;
          rcnt_d[i]  = '0;
        end else begin
          rcnt_d[i] = rcnt_q[i] + RW'(1);
        end
      end
`endif
    end
  end

  // State and output registers; reset returns every key to not-pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
`ifdef KEY_REPEAT_EN
        rcnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q   <= raw;
      sync_q    <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
`ifdef KEY_REPEAT_EN
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

endmodule
